// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the program-memory load arbiter.
// The loader FSM states and the packing geometry live here.
package imem_load_arbiter_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    LOAD    = 3'd2,
    COMMIT  = 3'd3,
    RELEASE = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_load_arbiter_byte_packer.sv
// Packs loader bytes little-endian into a 32-bit word.
// Clearing after every commit keeps unfilled upper lanes at zero on an early last byte.
module imem_load_arbiter_byte_packer
  import imem_load_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic [31:0] word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (accept) begin
      word[{byte_idx, 3'b000} +: 8] <= byte_in;
      byte_idx                      <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the program-memory port between fetch reads and a byte-stream loader.
// A load stalls the CPU, drains the pipeline, writes packed words and then restarts the CPU at 0.
//
// Loader handshake: a byte transfers on a rising clk edge where load_valid and
// load_ready are both high; load_ready is a pure state decode (high only in LOAD)
// and does not depend on load_valid, so the loader may hold valid indefinitely.
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  cpu_restart,
  output logic                  loading,
  output logic                  load_error,
  output logic [2:0]            debug_state
);

  localparam int DEPTH   = 2 ** (ADDR_WIDTH - 2);
  // One extra bit so word_ptr can sit at DEPTH to flag overflow without wrapping.
  localparam int PTR_W   = ADDR_WIDTH - 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  loader_state_t        state, state_next;
  logic [PTR_W-1:0]     word_ptr;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 last_seen;
  logic [1:0]           byte_idx;
  logic [31:0]          packed_word;
  logic                 accept;
  logic                 overflow;
  logic                 packer_clear;

  assign accept       = load_valid && (state == LOAD);
  assign overflow     = (word_ptr == PTR_W'(DEPTH));
  assign packer_clear = (state == COMMIT) || ((state == RUN) && load_start);

  imem_load_arbiter_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (packer_clear),
    .accept   (accept && !overflow),
    .byte_in  (load_byte),
    .byte_idx (byte_idx),
    .word     (packed_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (load_start) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = LOAD;
      LOAD: begin
        if (accept) begin
          if (overflow) begin
            if (load_last) state_next = RELEASE;
          end else if (load_last || byte_idx == 2'(BYTES_PER_WORD - 1)) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT:  state_next = last_seen ? RELEASE : LOAD;
      RELEASE: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_ptr   <= '0;
      drain_cnt  <= '0;
      last_seen  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_start) begin
            word_ptr   <= '0;
            drain_cnt  <= '0;
            last_seen  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        LOAD: begin
          if (accept) begin
            if (overflow)       load_error <= 1'b1;
            else if (load_last) last_seen  <= 1'b1;
          end
        end
        COMMIT: begin
          word_ptr  <= word_ptr + 1'b1;
          last_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign load_ready       = (state == LOAD);
  assign mem_write_enable = (state == COMMIT);
  assign cpu_restart      = (state == RELEASE);
  assign loading          = (state != RUN);
  assign cpu_hold         = (state != RUN);
  assign debug_state      = state;

  assign mem_address    = (state == COMMIT) ? {word_ptr[ADDR_WIDTH-3:0], 2'b00} : fetch_address;
  assign mem_write_data = (state == COMMIT) ? DATA_WIDTH'(packed_word) : '0;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: randomized byte images scored against a
// word-level model of what the program memory should receive.
module tb_imem_load_arbiter;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2 ** (ADDR_WIDTH - 2);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  load_start;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  cpu_hold;
  logic                  cpu_restart;
  logic                  loading;
  logic                  load_error;
  logic [2:0]            debug_state;

  int checks = 0;
  int errors = 0;

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_q[$];
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] got_q[$];
  int        restart_cnt;
  logic      exp_err;
  logic [7:0] img[64];

  imem_load_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DRAIN_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_byte        (load_byte),
    .load_last        (load_last),
    .load_ready       (load_ready),
    .fetch_address    (fetch_address),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .cpu_restart      (cpu_restart),
    .loading          (loading),
    .load_error       (load_error),
    .debug_state      (debug_state)
  );

  // clock / monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write_enable) got_q.push_back({mem_address, mem_write_data});
    if (cpu_restart) restart_cnt++;
  end

  // reference: which words the image should produce, and whether it overflows
  task automatic build_model(input int n);
    logic [31:0] word;
    exp_q.delete();
    exp_err = 1'b0;
    word = '0;
    for (int i = 0; i < n; i++) begin
      if (i / 4 < DEPTH) begin
        word = word | (32'(img[i]) << (8 * (i % 4)));
        if ((i % 4 == 3) || (i == n - 1)) begin
          exp_q.push_back({5'(4 * (i / 4)), word});
          word = '0;
        end
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    load_start = ($urandom_range(0, 3) == 0);
    t = 0;
    while (!load_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!load_ready) begin
      errors++;
      $display("FAIL byte_accept_timeout: load_ready=%b required 1", load_ready);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  // full load scenario: drain timing, byte stream, scoreboard, return to RUN
  task automatic run_image(input int n, input int max_gap);
    int t;
    build_model(n);
    got_q.delete();
    restart_cnt = 0;
    start_load();
    checks++;
    if (cpu_hold !== 1'b1 || load_ready !== 1'b0 || loading !== 1'b1 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL drain_cycle1: hold=%b ready=%b loading=%b err=%b required 1 0 1 0",
               cpu_hold, load_ready, loading, load_error);
    end
    @(posedge clk); #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_cycle2: load_ready=%b required 0", load_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_cycle3: load_ready=%b required 1", load_ready);
    end
    for (int i = 0; i < n; i++) send_byte(img[i], (i == n - 1), $urandom_range(0, max_gap));
    t = 0;
    while (loading && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (loading !== 1'b0) begin
      errors++;
      $display("FAIL return_to_run: loading=%b required 0", loading);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_count: got %0d writes required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL write_%0d: addr/data=%h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (restart_cnt != 1) begin
      errors++;
      $display("FAIL restart_pulses: got %0d required 1", restart_cnt);
    end
    checks++;
    if (load_error !== exp_err) begin
      errors++;
      $display("FAIL load_error: got %b required %b", load_error, exp_err);
    end
    fetch_address = 5'($urandom);
    #1;
    checks++;
    if (mem_address !== fetch_address || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL run_mux: mem_address=%h hold=%b required %h 0", mem_address, cpu_hold, fetch_address);
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_byte = '0;
    load_last = 1'b0;
    fetch_address = 5'h0C;
    #1;
    checks++;
    if (mem_address !== 5'h0C || mem_write_enable !== 1'b0 || mem_write_data !== '0 ||
        cpu_hold !== 1'b0 || cpu_restart !== 1'b0 || loading !== 1'b0 ||
        load_ready !== 1'b0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: addr=%h we=%b wd=%h hold=%b rst=%b ld=%b rdy=%b err=%b",
               mem_address, mem_write_enable, mem_write_data, cpu_hold, cpu_restart,
               loading, load_ready, load_error);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_address !== 5'h0C || loading !== 1'b0 || cpu_hold !== 1'b0 || mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_run: addr=%h loading=%b hold=%b we=%b required 0c 0 0 0",
               mem_address, loading, cpu_hold, mem_write_enable);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] b[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 8; i++) img[i] = b[i];
    run_image(8, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== {5'h00, 32'h12345678} || got_q[1] !== {5'h04, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL two_words_literal: writes=%0d required 00:12345678 04:deadbeef", got_q.size());
    end
  endtask

  task automatic test_short_word();
    img[0] = 8'hAA;
    img[1] = 8'hBB;
    run_image(2, 1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {5'h00, 32'h0000BBAA}) begin
      errors++;
      $display("FAIL short_word_literal: writes=%0d required 00:0000bbaa", got_q.size());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    run_image(33, 1);
    img[0] = 8'h5A;
    run_image(1, 0);
  endtask

  task automatic test_random_images();
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 38);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      run_image(n, 2);
    end
  endtask

  task automatic test_reset_in_commit();
    int t;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 0);
    t = 0;
    while (!mem_write_enable && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mem_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL reach_commit: mem_write_enable=%b required 1", mem_write_enable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0 || debug_state !== 3'd0 || load_ready !== 1'b0 ||
        cpu_hold !== 1'b0 || loading !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_commit: we=%b state=%0d rdy=%b hold=%b loading=%b required 0 0 0 0 0",
               mem_write_enable, debug_state, load_ready, cpu_hold, loading);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_short_word();
    test_overflow();
    test_random_images();
    test_reset_in_commit();
    img[0] = 8'h11;
    img[1] = 8'h22;
    img[2] = 8'h33;
    run_image(3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
